// File: rtl/dcache_resp.sv
// rtl/dcache_resp.sv - data-cache responder for the AGU->DCache request path
//
// Two-stage load/store pipeline over a small byte-addressed word array.
//   S0 -> S1 : request registered unconditionally every cycle.
//   S1       : kill/brkill qualification, alignment check, store commit,
//              combinational load read and extension.
//   S2       : registered load result; brkill may still squash it here.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_req_*                   request from the AGU (valid, we, funct3, addr,
//                             store data, dest tag, branch mask)
//   i_kill                    late kill of the request in S1
//   i_brkill                  branch-kill vector, applies to S1 and S2
//   o_valid, o_rd, o_data     load writeback (S2)
//   o_misalign                S2 request was misaligned and dropped
module dcache_resp #(
  parameter int WIDTH_MEM = 6,
  parameter int WIDTH_BRM = 4,
  parameter int WIDTH_REG = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req_val,
  input  logic                    i_req_we,
  input  logic [2:0]              i_req_func,
  input  logic [WIDTH_MEM-1:0]    i_req_addr,
  input  logic [31:0]             i_req_data,
  input  logic [WIDTH_REG-1:0]    i_req_rd,
  input  logic [2**WIDTH_BRM-1:0] i_req_brmask,
  input  logic                    i_kill,
  input  logic [2**WIDTH_BRM-1:0] i_brkill,
  output logic                    o_valid,
  output logic [WIDTH_REG-1:0]    o_rd,
  output logic [31:0]             o_data,
  output logic                    o_misalign
);

  localparam int DEPTH = 2**(WIDTH_MEM-2);
  localparam int NBR   = 2**WIDTH_BRM;

  // S1 state
  logic                 s1_val_q,    s1_val_d;
  logic                 s1_we_q,     s1_we_d;
  logic [2:0]           s1_func_q,   s1_func_d;
  logic [WIDTH_MEM-1:0] s1_addr_q,   s1_addr_d;
  logic [31:0]          s1_data_q,   s1_data_d;
  logic [WIDTH_REG-1:0] s1_rd_q,     s1_rd_d;
  logic [NBR-1:0]       s1_brmask_q, s1_brmask_d;

  // S2 state
  logic                 s2_val_q,     s2_val_d;
  logic                 s2_load_q,    s2_load_d;
  logic                 s2_aligned_q, s2_aligned_d;
  logic [WIDTH_REG-1:0] s2_rd_q,      s2_rd_d;
  logic [31:0]          s2_data_q,    s2_data_d;
  logic [NBR-1:0]       s2_brmask_q,  s2_brmask_d;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];

  logic                 s1_live;
  logic                 s1_aligned;
  logic [WIDTH_MEM-3:0] word_idx;
  logic [31:0]          rd_word;
  logic [7:0]           rd_byte;
  logic [15:0]          rd_half;
  logic [31:0]          ld_data;
  logic [3:0]           wr_be;
  logic [31:0]          wr_data;

  always_comb begin
    s1_val_d    = i_req_val;
    s1_we_d     = i_req_we;
    s1_func_d   = i_req_func;
    s1_addr_d   = i_req_addr;
    s1_data_d   = i_req_data;
    s1_rd_d     = i_req_rd;
    s1_brmask_d = i_req_brmask;
  end

  always_comb begin
    s1_live = s1_val_q & ~i_kill & ((s1_brmask_q & i_brkill) == '0);

    // Reserved funct3 encodings fall into the misaligned bucket.
    case (s1_func_q)
      3'b000, 3'b100: s1_aligned = 1'b1;
      3'b001, 3'b101: s1_aligned = ~s1_addr_q[0];
      3'b010:         s1_aligned = (s1_addr_q[1:0] == 2'b00);
      default:        s1_aligned = 1'b0;
    endcase

    word_idx = s1_addr_q[WIDTH_MEM-1:2];
    rd_word  = mem_q[word_idx];
    rd_byte  = rd_word[{s1_addr_q[1:0], 3'b000} +: 8];
    rd_half  = rd_word[{s1_addr_q[1], 4'b0000} +: 16];

    case (s1_func_q)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b100:  ld_data = {24'h0, rd_byte};
      3'b101:  ld_data = {16'h0, rd_half};
      default: ld_data = rd_word;
    endcase

    // Store data is replicated across lanes so the byte enables alone pick
    // which lanes change.
    case (s1_func_q[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << s1_addr_q[1:0];
        wr_data = {4{s1_data_q[7:0]}};
      end
      2'b01: begin
        wr_be   = s1_addr_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{s1_data_q[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = s1_data_q;
      end
    endcase

    for (int w = 0; w < DEPTH; w++) mem_d[w] = mem_q[w];
    if (s1_live && s1_we_q && s1_aligned) begin
      for (int l = 0; l < 4; l++) begin
        if (wr_be[l]) mem_d[word_idx][8*l +: 8] = wr_data[8*l +: 8];
      end
    end

    s2_val_d     = s1_live;
    s2_load_d    = ~s1_we_q;
    s2_aligned_d = s1_aligned;
    s2_rd_d      = s1_rd_q;
    s2_data_d    = ld_data;
    s2_brmask_d  = s1_brmask_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_val_q     <= 1'b0;
      s1_we_q      <= 1'b0;
      s1_func_q    <= '0;
      s1_addr_q    <= '0;
      s1_data_q    <= '0;
      s1_rd_q      <= '0;
      s1_brmask_q  <= '0;
      s2_val_q     <= 1'b0;
      s2_load_q    <= 1'b0;
      s2_aligned_q <= 1'b0;
      s2_rd_q      <= '0;
      s2_data_q    <= '0;
      s2_brmask_q  <= '0;
      for (int w = 0; w < DEPTH; w++) mem_q[w] <= '0;
    end else begin
      s1_val_q     <= s1_val_d;
      s1_we_q      <= s1_we_d;
      s1_func_q    <= s1_func_d;
      s1_addr_q    <= s1_addr_d;
      s1_data_q    <= s1_data_d;
      s1_rd_q      <= s1_rd_d;
      s1_brmask_q  <= s1_brmask_d;
      s2_val_q     <= s2_val_d;
      s2_load_q    <= s2_load_d;
      s2_aligned_q <= s2_aligned_d;
      s2_rd_q      <= s2_rd_d;
      s2_data_q    <= s2_data_d;
      s2_brmask_q  <= s2_brmask_d;
      for (int w = 0; w < DEPTH; w++) mem_q[w] <= mem_d[w];
    end
  end

  // A branch kill in S2 squashes both the writeback and the misalign report.
  logic s2_alive;
  assign s2_alive   = s2_val_q & ((s2_brmask_q & i_brkill) == '0);
  assign o_valid    = s2_alive & s2_load_q & s2_aligned_q;
  assign o_misalign = s2_alive & ~s2_aligned_q;
  assign o_rd       = s2_rd_q;
  assign o_data     = s2_data_q;

endmodule

// File: tb/tb_dcache_resp.sv
// tb/tb_dcache_resp.sv - scoreboard testbench for dcache_resp
module tb_dcache_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_val = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_func = '0;
  logic [5:0]  req_addr = '0;
  logic [31:0] req_data = '0;
  logic [4:0]  req_rd = '0;
  logic [15:0] req_brmask = '0;
  logic        kill = 1'b0;
  logic [15:0] brkill = '0;
  logic        o_valid;
  logic [4:0]  o_rd;
  logic [31:0] o_data;
  logic        o_misalign;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          mis;
    logic [4:0]  rd;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t sb[$];

  dcache_resp #(.WIDTH_MEM(6), .WIDTH_BRM(4), .WIDTH_REG(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_val(req_val), .i_req_we(req_we), .i_req_func(req_func),
    .i_req_addr(req_addr), .i_req_data(req_data), .i_req_rd(req_rd),
    .i_req_brmask(req_brmask), .i_kill(kill), .i_brkill(brkill),
    .o_valid(o_valid), .o_rd(o_rd), .o_data(o_data), .o_misalign(o_misalign)
  );

  always #5 clk = ~clk;

  // Monitor: pops one expectation whenever the DUT presents a result.
  always @(negedge clk) begin
    if (rst_n && (o_valid || o_misalign)) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out: valid=%0b misalign=%0b rd=%0d data=%h, none expected",
                 o_valid, o_misalign, o_rd, o_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.mis) begin
          if (!(o_misalign && !o_valid)) begin
            n_err++;
            $display("FAIL %s: valid=%0b misalign=%0b, required valid=0 misalign=1",
                     e.name, o_valid, o_misalign);
          end
        end else if (!(o_valid && !o_misalign && o_rd == e.rd && o_data == e.data)) begin
          n_err++;
          $display("FAIL %s: valid=%0b misalign=%0b rd=%0d data=%h, required valid=1 rd=%0d data=%h",
                   e.name, o_valid, o_misalign, o_rd, o_data, e.rd, e.data);
        end
      end
    end
  end

  task automatic step(input logic val, input logic we, input logic [2:0] func,
                      input logic [5:0] addr, input logic [31:0] data,
                      input logic [4:0] rd, input logic [15:0] brm,
                      input logic k, input logic [15:0] bk);
    req_val = val; req_we = we; req_func = func; req_addr = addr;
    req_data = data; req_rd = rd; req_brmask = brm; kill = k; brkill = bk;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic k, input logic [15:0] bk);
    step(1'b0, 1'b0, 3'b000, 6'h00, 32'h0, 5'd0, 16'h0, k, bk);
  endtask

  task automatic st(input logic [2:0] func, input logic [5:0] addr,
                    input logic [31:0] data, input logic [15:0] brm);
    step(1'b1, 1'b1, func, addr, data, 5'd0, brm, 1'b0, 16'h0);
  endtask

  task automatic ld(input logic [2:0] func, input logic [5:0] addr,
                    input logic [4:0] rd, input logic [31:0] exp_data, input string name);
    exp_t e;
    e.mis = 1'b0; e.rd = rd; e.data = exp_data; e.name = name;
    sb.push_back(e);
    step(1'b1, 1'b0, func, addr, 32'h0, rd, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic expect_mis(input string name);
    exp_t e;
    e.mis = 1'b1; e.rd = '0; e.data = '0; e.name = name;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'h0, o_valid}, 32'h0);
    chk("rst_misalign", {31'h0, o_misalign}, 32'h0);
    chk("rst_rd", {27'h0, o_rd}, 32'h0);
    chk("rst_data", o_data, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    ld(3'b010, 6'h08, 5'd7, 32'h00000000, "lw_08_after_reset");
    st(3'b010, 6'h04, 32'hDEADBEEF, 16'h0);
    ld(3'b010, 6'h04, 5'd3, 32'hDEADBEEF, "lw_04_fwd");
    st(3'b000, 6'h05, 32'h12345680, 16'h0);
    ld(3'b000, 6'h05, 5'd4, 32'hFFFFFF80, "lb_05");
    ld(3'b100, 6'h05, 5'd5, 32'h00000080, "lbu_05");
    ld(3'b010, 6'h04, 5'd6, 32'hDEAD80EF, "lw_04_merged");
    ld(3'b001, 6'h06, 5'd8, 32'hFFFFDEAD, "lh_06");
    ld(3'b101, 6'h06, 5'd9, 32'h0000DEAD, "lhu_06");
    ld(3'b001, 6'h04, 5'd10, 32'hFFFF80EF, "lh_04");
    ld(3'b000, 6'h07, 5'd11, 32'hFFFFFFDE, "lb_07");

    // Store killed in S1 by i_kill
    st(3'b010, 6'h0C, 32'h11112222, 16'h0);
    idle(1'b1, 16'h0);
    ld(3'b010, 6'h0C, 5'd12, 32'h00000000, "lw_0c_killed_store");

    // Load squashed by brkill in its S2 cycle: no output expected
    step(1'b1, 1'b0, 3'b010, 6'h0C, 32'h0, 5'd13, 16'h0002, 1'b0, 16'h0);
    idle(1'b0, 16'h0);
    idle(1'b0, 16'h0002);

    // Misaligned halfword store: reported, word 0x00 untouched
    expect_mis("sh_03_misalign");
    st(3'b001, 6'h03, 32'h00001234, 16'h0);
    ld(3'b010, 6'h00, 5'd14, 32'h00000000, "lw_00_after_misalign");

    // i_kill and i_brkill together on a store
    st(3'b010, 6'h10, 32'h00000055, 16'h0001);
    idle(1'b1, 16'h0001);
    ld(3'b010, 6'h10, 5'd15, 32'h00000000, "lw_10_double_kill");

    // brkill hitting in S1
    st(3'b010, 6'h14, 32'hAABBCCDD, 16'h0008);
    idle(1'b0, 16'h0008);
    ld(3'b010, 6'h14, 5'd16, 32'h00000000, "lw_14_brkill_s1");

    // Non-matching brkill leaves the store alive, then a halfword overlay
    st(3'b010, 6'h18, 32'h0BADF00D, 16'h0004);
    idle(1'b0, 16'h0002);
    ld(3'b010, 6'h18, 5'd17, 32'h0BADF00D, "lw_18_brkill_miss");
    st(3'b001, 6'h1A, 32'h0000BEEF, 16'h0);
    ld(3'b010, 6'h18, 5'd18, 32'hBEEFF00D, "lw_18_sh_overlay");

    // Reserved funct3 and misaligned word load
    expect_mis("func011_misalign");
    step(1'b1, 1'b0, 3'b011, 6'h20, 32'h0, 5'd19, 16'h0, 1'b0, 16'h0);
    expect_mis("lw_22_misalign");
    step(1'b1, 1'b0, 3'b010, 6'h22, 32'h0, 5'd20, 16'h0, 1'b0, 16'h0);

    // Top word of the array
    st(3'b010, 6'h3C, 32'hCAFEF00D, 16'h0);
    ld(3'b010, 6'h3C, 5'd21, 32'hCAFEF00D, "lw_3c_top");
    ld(3'b100, 6'h3F, 5'd22, 32'h000000CA, "lbu_3f");

    repeat (4) idle(1'b0, 16'h0);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
